// File: rtl/router_output_arbiter.sv
// Per-output packet arbiter for the router crossbar.
// Round-robin, packet-granular grant: an input that has been shown the grant
// keeps it until its last flit completes the handshake.
module router_output_arbiter #(
  parameter int unsigned      N_REQ    = 10,
  parameter logic [N_REQ-1:0] REQ_MASK = '0,
  parameter int unsigned      IDX_W    = $clog2(N_REQ),
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_last,
  input  logic             out_ready,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             out_valid,
  output logic             fire,
  output logic             locked,
  output logic [CNT_W-1:0] pkt_count
);

  // One extra bit so ptr + offset cannot overflow before the wrap compare.
  localparam int unsigned      SUM_W    = IDX_W + 1;
  localparam logic [SUM_W-1:0] N_SUM    = SUM_W'(N_REQ);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] elig;
  logic [SUM_W-1:0] cand;
  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] sel_inc;
  logic             sel_vld;
  logic             last_sel;

  // Statically disabled inputs never take part in arbitration.
  assign elig = req & ~REQ_MASK;

  // First eligible input at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + SUM_W'(i);
      if (cand >= N_SUM) cand = cand - N_SUM;
      if (!pick_vld && elig[cand[IDX_W-1:0]]) begin
        pick     = cand[IDX_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  // Grant select, stream outputs and next-state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant   = '0;

    // Owner is held regardless of req; grant is suppressed while in reset.
    if (state_q == ST_LOCKED) begin
      sel     = owner_q;
      sel_vld = rst_n;
    end else begin
      sel     = pick;
      sel_vld = pick_vld && rst_n;
    end

    if (sel_vld) grant[sel] = 1'b1;
    grant_idx = sel_vld ? sel : '0;
    out_valid = |(grant & req);
    fire      = out_valid && out_ready;
    last_sel  = req_last[sel];
    sel_inc   = (sel == IDX_LAST) ? '0 : sel + IDX_W'(1);
    locked    = (state_q == ST_LOCKED);

    if (sel_vld) begin
      if (fire && last_sel) begin
        state_d = ST_IDLE;
        ptr_d   = sel_inc;
        cnt_d   = cnt_q + CNT_W'(1);
      end else if (state_q == ST_IDLE) begin
        state_d = ST_LOCKED;
        owner_d = sel;
      end
    end
  end

  // State, pointer, owner and packet counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter: default instance plus a masked,
// 4-bit-counter instance.
module tb_router_output_arbiter;

  logic       clk;
  logic       rst_n;

  logic [9:0]  req, req_last;
  logic        out_ready;
  logic [9:0]  grant;
  logic [3:0]  grant_idx;
  logic        out_valid, fire, locked;
  logic [15:0] pkt_count;

  logic [9:0]  req_m, req_last_m;
  logic        out_ready_m;
  logic [9:0]  grant_m;
  logic [3:0]  grant_idx_m;
  logic        out_valid_m, fire_m, locked_m;
  logic [3:0]  pkt_count_m;

  int n_checks;
  int n_fail;

  int exp_idx [8] = '{3, 3, 3, 3, 7, 7, 7, 7};
  int exp_lock[8] = '{0, 1, 1, 1, 0, 1, 1, 1};

  router_output_arbiter u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_last  (req_last),
    .out_ready (out_ready),
    .grant     (grant),
    .grant_idx (grant_idx),
    .out_valid (out_valid),
    .fire      (fire),
    .locked    (locked),
    .pkt_count (pkt_count)
  );

  router_output_arbiter #(
    .N_REQ    (10),
    .REQ_MASK (10'b0000000011),
    .CNT_W    (4)
  ) u_dut_m (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_m),
    .req_last  (req_last_m),
    .out_ready (out_ready_m),
    .grant     (grant_m),
    .grant_idx (grant_idx_m),
    .out_valid (out_valid_m),
    .fire      (fire_m),
    .locked    (locked_m),
    .pkt_count (pkt_count_m)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it mismatches.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge, away from it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    req         = 10'h3FF;
    req_last    = 10'h000;
    out_ready   = 1'b0;
    req_m       = 10'h000;
    req_last_m  = 10'h000;
    out_ready_m = 1'b0;

    // Reset with every input requesting: nothing is granted.
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_pkt", 32'(pkt_count), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    tick;
    tick;
    req   = 10'h000;
    rst_n = 1'b1;
    #1;
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_idx", 32'(grant_idx), 32'h0);
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_fire", 32'(fire), 32'h0);
    check("idle_locked", 32'(locked), 32'h0);
    tick;
    check("idle_pkt", 32'(pkt_count), 32'h0);

    // Two 4-flit packets from inputs 3 and 7.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req      = (k < 4) ? 10'h088 : 10'h080;
      req_last = ((k % 4) == 3) ? 10'h3FF : 10'h000;
      #1;
      check("mf_idx", 32'(grant_idx), 32'(exp_idx[k]));
      check("mf_locked", 32'(locked), 32'(exp_lock[k]));
      check("mf_fire", 32'(fire), 32'h1);
      tick;
    end
    req      = 10'h000;
    req_last = 10'h000;
    #1;
    check("mf_unlock", 32'(locked), 32'h0);
    check("mf_pkt", 32'(pkt_count), 32'd2);
    check("mf_grant0", 32'(grant), 32'h0);

    // Reset to bring ptr back to 0 before the round-robin sweep.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;

    // All inputs send single-flit packets: 0..9 then 0, no bubbles.
    req      = 10'h3FF;
    req_last = 10'h3FF;
    for (int k = 0; k < 11; k++) begin
      #1;
      check("rr_idx", 32'(grant_idx), 32'(k % 10));
      check("rr_fire", 32'(fire), 32'h1);
      tick;
    end
    req = 10'h000;
    #1;
    check("rr_pkt", 32'(pkt_count), 32'd11);

    // Stall on input 2 (ptr is 1) while input 0 starts requesting.
    out_ready = 1'b0;
    req_last  = 10'h000;
    for (int k = 0; k < 5; k++) begin
      req = (k == 0) ? 10'h004 : 10'h005;
      #1;
      check("st_idx", 32'(grant_idx), 32'd2);
      check("st_locked", 32'(locked), (k == 0) ? 32'h0 : 32'h1);
      check("st_valid", 32'(out_valid), 32'h1);
      check("st_fire", 32'(fire), 32'h0);
      tick;
    end
    out_ready = 1'b1;
    req_last  = 10'h004;
    #1;
    check("st_last_idx", 32'(grant_idx), 32'd2);
    check("st_last_fire", 32'(fire), 32'h1);
    tick;
    req      = 10'h001;
    req_last = 10'h001;
    #1;
    check("st_next_idx", 32'(grant_idx), 32'd0);
    check("st_next_locked", 32'(locked), 32'h0);
    tick;
    req = 10'h000;
    #1;
    check("st_pkt", 32'(pkt_count), 32'd13);

    // Reset mid-packet: lock is dropped at once and ptr returns to 0.
    req      = 10'h020;
    req_last = 10'h000;
    #1;
    check("mr_idx", 32'(grant_idx), 32'd5);
    tick;
    check("mr_locked", 32'(locked), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mr_rst_locked", 32'(locked), 32'h0);
    check("mr_rst_grant", 32'(grant), 32'h0);
    tick;
    rst_n = 1'b1;
    req   = 10'h201;
    #1;
    check("mr_ptr_idx", 32'(grant_idx), 32'd0);
    check("mr_pkt", 32'(pkt_count), 32'd0);
    req = 10'h000;
    tick;

    // Masked inputs 0 and 1 are never granted.
    req_m       = 10'h003;
    req_last_m  = 10'h3FF;
    out_ready_m = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mask_grant", 32'(grant_m), 32'h0);
      check("mask_valid", 32'(out_valid_m), 32'h0);
      tick;
    end
    check("mask_pkt", 32'(pkt_count_m), 32'h0);

    // Input 4 joins: 17 single-flit packets wrap the 4-bit counter to 1.
    req_m = 10'h013;
    for (int k = 0; k < 17; k++) begin
      #1;
      check("wrap_grant", 32'(grant_m), 32'h010);
      if (k == 0) check("wrap_idx", 32'(grant_idx_m), 32'd4);
      if (k == 16) check("wrap_pkt16", 32'(pkt_count_m), 32'd0);
      tick;
    end
    check("wrap_pkt17", 32'(pkt_count_m), 32'd1);
    req_m = 10'h000;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_output_arbiter.md
# router_output_arbiter

Per-output packet arbiter for the router crossbar. Each crossbar output owns one instance that chooses which input stream may drive it. Grants are round-robin and packet-granular: once an input has been presented to the output, it keeps the output until its `last` flit completes the handshake. This enforces the "target stable until last" rule that the crossbar datapath relies on. The block drives the crossbar's per-output select and ready gating; it holds no payload.

## Interface
- `N_REQ`, default 10: number of requesting inputs (crossbar ports).
- `REQ_MASK`, default `'0`: per-input static disable. A set bit means that input is never granted; used for the unconnected diagonal crossbar elements.
- `IDX_W`, default `$clog2(N_REQ)`: width of the grant index.
- `CNT_W`, default 16: width of the packet counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input N_REQ: input i is valid and targets this output.
- `req_last` input N_REQ: `last` flag of the flit currently offered by input i.
- `out_ready` input 1: downstream ready of this output.
- `grant` output N_REQ: one-hot grant, or all zero.
- `grant_idx` output IDX_W: binary index of the granted input; 0 when `grant` is zero.
- `out_valid` output 1: `|(grant & req)`; drives the output stream valid.
- `fire` output 1: `out_valid && out_ready`; drives the granted input's ready.
- `locked` output 1: high while state is LOCKED.
- `pkt_count` output CNT_W: number of packets completed (last flit fired); wraps modulo 2^CNT_W.

## Operation
- Eligible requests: `elig = req & ~REQ_MASK`.
- Round-robin pick: the first set bit of `elig` at or above pointer `ptr`, searching upward and wrapping modulo N_REQ.
- State IDLE:
  - `grant = onehot(pick)` is combinational; zero if `elig` is zero.
  - If `elig` is non-zero and (`!fire` or `!req_last[pick]`): go to LOCKED and latch `owner <= pick`.
  - If `fire && req_last[pick]` (single-flit packet): stay in IDLE, set `ptr <= (pick+1) mod N_REQ`, and increment `pkt_count`.
  - If `elig` is zero: stay in IDLE; `ptr` is unchanged.
- State LOCKED:
  - `grant = onehot(owner)`, independent of `req` and `ptr`.
  - `out_valid` follows `req[owner]`.
  - If `fire && req_last[owner]`: go to IDLE, set `ptr <= (owner+1) mod N_REQ`, and increment `pkt_count`.
  - Otherwise stay in LOCKED.
- Lock-on-presentation: an input that has been shown `grant` stays granted in later cycles even if no handshake occurred. This keeps the output's valid/payload stable while stalled.
- Inputs follow stream rules and never drop `req` mid-packet. If `req[owner]` drops anyway, the grant is held, `out_valid` is 0, and there is no error state.
- `REQ_MASK` bits are never granted, even if the corresponding `req` bit is high.
- `N_REQ` must be 2 or more, and `N_REQ <= 2^IDX_W`. `ptr` wrap uses explicit compare-and-zero, not power-of-two truncation.

## Timing
- Reset (asynchronous assert, synchronous release) values:
  - state = IDLE, `ptr` = 0, `owner` = 0, `pkt_count` = 0, `locked` = 0.
  - `grant`, `grant_idx`, `out_valid` and `fire` are combinational and are 0 while `req` is 0.
- Grant latency is 0 cycles: a request seen in IDLE is granted in the same cycle.
- Back-to-back packets: after the last flit fires in cycle t, the state in cycle t+1 is IDLE with the new `ptr`. A new grant is given in t+1, so there are no bubbles between packets.
- Fairness: with all N eligible inputs continuously requesting, each input is granted within N−1 packets of any other.
- Reset asserted mid-packet: the block returns to IDLE immediately and `ptr` is 0. The partially sent packet is the system's problem, and the crossbar resets together with this block.
- `fire` is purely combinational from `req`, `out_ready` and internal state. There is no combinational path from `out_ready` to `grant`.

## Test plan
- **Reset and idle:** assert `rst_n=0` with `req=10'h3FF` → `grant=0`, `pkt_count=0`, `locked=0`. Release reset with `req=0` → all outputs stay 0.
- **Multi-flit lock:** `req[3]=1`, `req[7]=1`, `ptr=0`, 4-flit packets, `out_ready=1` → `grant_idx=3` for 4 cycles, then `grant_idx=7` for 4 cycles; `pkt_count=2`. `locked` drops in the cycle after each last fire.
- **Round-robin order:** all 10 inputs issue repeated 1-flit packets with `out_ready=1` → grant sequence 0,1,…,9,0 with no idle cycles; `pkt_count=11` after 11 cycles.
- **Stall stability:** grant input 2 with `out_ready=0` for 5 cycles while `req[0]` rises → `grant_idx` stays 2 throughout and `locked=1`. Input 0 is granted only after input 2's last flit fires.
- **Mask:** `REQ_MASK=10'b0000000011` with `req=10'b0000000011` → `grant=0` permanently. Then add `req[4]` → `grant_idx=4`.
- **Counter wrap:** `CNT_W=4`, 17 single-flit packets → `pkt_count` reads 1.
